reduz_media: RTL

Block-averaging downscaler for the coprocessor's zoom-out operations. It reads a LARGURA×ALTURA 8-bit greyscale source image from the synchronous image ROM. It averages each fator×fator tile into one output pixel and writes the reduced image, row-major, into the framebuffer RAM. It is the zoom-out counterpart of the pixel-replication zoom-in path and uses the same ROM/RAM port style, so the ULA mux selects between the two.

---
 rtl/reduz_media.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/reduz_media.sv
// reduz_media: averages each fator x fator tile of the source ROM image
// into one framebuffer pixel (fator 1/2/4), row-major output order.
// Ports: clk, reset (async, active-low), start, fator[2:0] latched at start;
// rom_addr/rom_data source port (2-edge read latency);
// ram_wraddr/ram_data/ram_wren destination port; busy, done, erro status.
module reduz_media #(
  parameter int LARGURA = 160,
  parameter int ALTURA  = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  fator,
  output logic [18:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [18:0] ram_wraddr,
  output logic [7:0]  ram_data,
  output logic        ram_wren,
  output logic        busy,
  output logic        done,
  output logic        erro
);

  typedef enum logic [1:0] {
    IDLE, LER, ESCR, DONE
  } est_t;

  localparam logic [18:0] W = 19'(LARGURA);
  localparam logic [18:0] PM1_1 =
    19'(LARGURA * ALTURA - 1);
  localparam logic [18:0] PM1_2 =
    19'((LARGURA >> 1) * (ALTURA >> 1) - 1);
  localparam logic [18:0] PM1_4 =
    19'((LARGURA >> 2) * (ALTURA >> 2) - 1);
  localparam logic [18:0] OWM1_1 = 19'(LARGURA - 1);
  localparam logic [18:0] OWM1_2 = 19'((LARGURA >> 1) - 1);
  localparam logic [18:0] OWM1_4 = 19'((LARGURA >> 2) - 1);

  est_t        est;
  logic [1:0]  k_q;
  logic [4:0]  ph;
  logic [1:0]  dj;
  logic [18:0] ptr;
  logic [18:0] tbase;
  logic [18:0] ox;
  logic [18:0] oidx;
  logic [11:0] acc;

  logic        legal;
  logic [1:0]  kf;
  logic [18:0] fs;
  logic [18:0] f19;
  logic [1:0]  fm1;
  logic [4:0]  n_s;
  logic [18:0] ow_m1;
  logic [18:0] p_m1;
  logic [18:0] nb;
  logic [11:0] sum;
  logic [7:0]  avg;

  // Next issue address inside a tile: step right, or wrap to the
  // first column of the next tile row.
  function automatic logic [18:0] step(
    input logic [18:0] a,
    input logic        last,
    input logic [18:0] f
  );
    if (last) step = a + W + 19'd1 - f;
    else      step = a + 19'd1;
  endfunction

  always_comb begin
    legal = 1'b0;
    kf    = 2'd0;
    unique case (1'b1)
      (fator == 3'd1): begin legal = 1'b1; kf = 2'd0; end
      (fator == 3'd2): begin legal = 1'b1; kf = 2'd1; end
      (fator == 3'd4): begin legal = 1'b1; kf = 2'd2; end
      default:         legal = 1'b0;
    endcase
  end

  always_comb begin
    n_s   = 5'd1;
    ow_m1 = OWM1_1;
    p_m1  = PM1_1;
    avg   = sum[7:0];
    unique case (k_q)
      2'd1: begin
        n_s = 5'd4; ow_m1 = OWM1_2;
        p_m1 = PM1_2; avg = sum[9:2];
      end
      2'd2: begin
        n_s = 5'd16; ow_m1 = OWM1_4;
        p_m1 = PM1_4; avg = sum[11:4];
      end
      default: begin
        n_s = 5'd1; ow_m1 = OWM1_1;
        p_m1 = PM1_1; avg = sum[7:0];
      end
    endcase
  end

  assign fs  = 19'd1 << kf;
  assign f19 = 19'd1 << k_q;
  assign fm1 = 2'(f19 - 19'd1);
  assign sum = acc + {4'd0, rom_data};

  // Tile after the last one of a row starts fator rows further down.
  assign nb = (ox == ow_m1)
            ? tbase + (W << k_q) - W + f19
            : tbase + f19;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      est        <= IDLE;
      k_q        <= 2'd0;
      ph         <= 5'd0;
      dj         <= 2'd0;
      ptr        <= 19'd0;
      tbase      <= 19'd0;
      ox         <= 19'd0;
      oidx       <= 19'd0;
      acc        <= 12'd0;
      rom_addr   <= 19'd0;
      ram_wraddr <= 19'd0;
      ram_data   <= 8'd0;
      ram_wren   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      erro       <= 1'b0;
    end else begin
      ram_wren <= 1'b0;
      unique case (est)
        IDLE, DONE: begin
          if (start && legal) begin
            k_q      <= kf;
            busy     <= 1'b1;
            done     <= 1'b0;
            erro     <= 1'b0;
            acc      <= 12'd0;
            tbase    <= 19'd0;
            ox       <= 19'd0;
            oidx     <= 19'd0;
            rom_addr <= 19'd0;
            ptr      <= step(19'd0, kf == 2'd0, fs);
            dj       <= (kf == 2'd0) ? 2'd0 : 2'd1;
            ph       <= 5'd1;
            est      <= LER;
          end else if (start) begin
            done <= 1'b1;
            erro <= 1'b1;
            est  <= DONE;
          end
        end
        LER: begin
          if (ph < n_s) begin
            rom_addr <= ptr;
            ptr      <= step(ptr, dj == fm1, f19);
            dj       <= (dj == fm1) ? 2'd0 : dj + 2'd1;
          end
          if (ph >= 5'd2 && ph <= n_s)
            acc <= sum;
          if (ph == n_s + 5'd1) begin
            ram_data   <= avg;
            ram_wraddr <= oidx;
            ram_wren   <= 1'b1;
            acc        <= 12'd0;
            est        <= ESCR;
          end else begin
            ph <= ph + 5'd1;
          end
        end
        ESCR: begin
          if (oidx == p_m1) begin
            busy <= 1'b0;
            done <= 1'b1;
            est  <= DONE;
          end else begin
            oidx     <= oidx + 19'd1;
            ox       <= (ox == ow_m1) ? 19'd0 : ox + 19'd1;
            tbase    <= nb;
            rom_addr <= nb;
            ptr      <= step(nb, k_q == 2'd0, f19);
            dj       <= (k_q == 2'd0) ? 2'd0 : 2'd1;
            ph       <= 5'd1;
            est      <= LER;
          end
        end
        default: est <= IDLE;
      endcase
    end
  end

endmodule
